// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse line decoder.
// Holds the FSM state encoding, symbol values, letter codes and default lengths.
// Imported by the decoder top and its lookup sub-module.
package morse_pkg;

  // Decoder FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  // Symbol values as they are shifted into the pattern register
  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  // Pattern storage widths: up to four symbols, count 0..4
  localparam int SYM_W  = 4;
  localparam int CNT_W  = 3;
  localparam int CODE_W = 3;

  // Letter select codes, matching the transmitter's S..Z select
  localparam logic [CODE_W-1:0] L_S = 3'd0;
  localparam logic [CODE_W-1:0] L_T = 3'd1;
  localparam logic [CODE_W-1:0] L_U = 3'd2;
  localparam logic [CODE_W-1:0] L_V = 3'd3;
  localparam logic [CODE_W-1:0] L_W = 3'd4;
  localparam logic [CODE_W-1:0] L_X = 3'd5;
  localparam logic [CODE_W-1:0] L_Y = 3'd6;
  localparam logic [CODE_W-1:0] L_Z = 3'd7;

  // Default timing, in sample ticks
  localparam int DEF_DOT_LEN     = 1;
  localparam int DEF_DASH_LEN    = 3;
  localparam int DEF_GAP_LEN     = 3;
  localparam int DEF_MAX_SYMBOLS = 4;
  localparam int DEF_RUN_W       = 3;

endpackage

// File: rtl/morse_decoder_if.sv
// Sample-tick input and decoded-letter output bundle of the Morse decoder.
// master drives the line and tick; slave (the decoder) drives the results.
// No flow control: results are single-clock pulses qualified by valid.
interface morse_decoder_if;
  logic       enable;
  logic       serial_in;
  logic [2:0] code;
  logic       valid;
  logic       error;
  logic       busy;

  modport master (
    output enable,
    output serial_in,
    input  code,
    input  valid,
    input  error,
    input  busy
  );

  modport slave (
    input  enable,
    input  serial_in,
    output code,
    output valid,
    output error,
    output busy
  );
endinterface

// File: rtl/morse_lookup.sv
// Maps a finished (symbol count, symbol pattern) pair to its S..Z letter code.
// Purely combinational, zero latency.
// hit is low for any pattern that is not one of the eight letters.
module morse_lookup
  import morse_pkg::*;
(
  input  logic [CNT_W-1:0]  sym_cnt,
  input  logic [SYM_W-1:0]  sym_bits,
  output logic [CODE_W-1:0] code,
  output logic              hit
);

  // Table match on count and pattern together; first symbol sits highest
  always_comb begin
    code = L_S;
    hit  = 1'b0;
    case ({sym_cnt, sym_bits})
      {3'd3, 4'b0000}: begin code = L_S; hit = 1'b1; end
      {3'd1, 4'b0001}: begin code = L_T; hit = 1'b1; end
      {3'd3, 4'b0001}: begin code = L_U; hit = 1'b1; end
      {3'd4, 4'b0001}: begin code = L_V; hit = 1'b1; end
      {3'd3, 4'b0011}: begin code = L_W; hit = 1'b1; end
      {3'd4, 4'b1001}: begin code = L_X; hit = 1'b1; end
      {3'd4, 4'b1011}: begin code = L_Y; hit = 1'b1; end
      {3'd4, 4'b1100}: begin code = L_Z; hit = 1'b1; end
      default:         begin code = L_S; hit = 1'b0; end
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Measures mark/space run lengths on the sampled Morse line and decodes S..Z.
// Latency: valid rises on the edge that samples the GAP_LEN-th space tick.
// No backpressure: results are one-clock pulses; enable=0 freezes all state.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int DOT_LEN     = DEF_DOT_LEN,
  parameter int DASH_LEN    = DEF_DASH_LEN,
  parameter int GAP_LEN     = DEF_GAP_LEN,
  parameter int MAX_SYMBOLS = DEF_MAX_SYMBOLS,
  parameter int RUN_W       = DEF_RUN_W
) (
  input logic             clock,
  input logic             clear,
  morse_decoder_if.slave  bus
);

  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0] DOT_R   = RUN_W'(DOT_LEN);
  localparam logic [RUN_W-1:0] DASH_R  = RUN_W'(DASH_LEN);
  localparam logic [RUN_W-1:0] GAP_R   = RUN_W'(GAP_LEN);
  localparam logic [CNT_W-1:0] MAX_R   = CNT_W'(MAX_SYMBOLS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state, state_nxt;
  logic [RUN_W-1:0]   run, run_nxt;
  logic [CNT_W-1:0]   sym_cnt, sym_cnt_nxt;
  logic [SYM_W-1:0]   sym_bits, sym_bits_nxt;
  logic               bad, bad_nxt;
  logic               sym;
  logic               finish;

  logic [CODE_W-1:0]  lk_code;
  logic               lk_hit;

  logic [CODE_W-1:0]  code_q, code_nxt;
  logic               valid_q, valid_nxt;
  logic               error_q, error_nxt;
  logic               busy_q, busy_nxt;

  morse_lookup u_lookup (
    .sym_cnt  (sym_cnt),
    .sym_bits (sym_bits),
    .code     (lk_code),
    .hit      (lk_hit)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run-length, symbol accumulator and malformed-letter flag registers
  always_ff @(posedge clock) begin
    if (!clear) begin
      run      <= '0;
      sym_cnt  <= '0;
      sym_bits <= '0;
      bad      <= 1'b0;
    end else begin
      run      <= run_nxt;
      sym_cnt  <= sym_cnt_nxt;
      sym_bits <= sym_bits_nxt;
      bad      <= bad_nxt;
    end
  end

  // Next-state: advance only on sample ticks, classify runs at line transitions
  always_comb begin
    state_nxt    = state;
    run_nxt      = run;
    sym_cnt_nxt  = sym_cnt;
    sym_bits_nxt = sym_bits;
    bad_nxt      = bad;
    sym          = SYM_DOT;
    finish       = 1'b0;
    if (bus.enable) begin
      case (state)
        IDLE: begin
          if (bus.serial_in) begin
            state_nxt    = MARK;
            run_nxt      = RUN_ONE;
            sym_cnt_nxt  = '0;
            sym_bits_nxt = '0;
            bad_nxt      = 1'b0;
          end
        end
        MARK: begin
          if (bus.serial_in) begin
            // Saturate so an endless mark never aliases back to a dot length
            if (run != RUN_MAX) begin
              run_nxt = run + RUN_ONE;
            end
          end else begin
            if (run == DASH_R) begin
              sym = SYM_DASH;
            end else if (run != DOT_R) begin
              bad_nxt = 1'b1;
            end
            if (sym_cnt == MAX_R) begin
              bad_nxt = 1'b1;
            end else begin
              sym_bits_nxt = {sym_bits[SYM_W-2:0], sym};
              sym_cnt_nxt  = sym_cnt + CNT_ONE;
            end
            state_nxt = SPACE;
            run_nxt   = RUN_ONE;
          end
        end
        SPACE: begin
          if (!bus.serial_in) begin
            run_nxt = run + RUN_ONE;
            if ((run + RUN_ONE) == GAP_R) begin
              finish    = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            // Only a one-dot space may separate symbols inside a letter
            if (run != DOT_R) begin
              bad_nxt = 1'b1;
            end
            state_nxt = MARK;
            run_nxt   = RUN_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output decode: latch the letter result on finish, valid is a single pulse
  always_comb begin
    valid_nxt = finish;
    code_nxt  = code_q;
    error_nxt = error_q;
    busy_nxt  = (state_nxt != IDLE);
    if (finish) begin
      code_nxt  = (lk_hit && !bad) ? lk_code : L_S;
      error_nxt = !lk_hit || bad;
    end
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (!clear) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      code_q  <= code_nxt;
      valid_q <= valid_nxt;
      error_q <= error_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.error = error_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: letter vectors plus reset/stall sequences.
// One sample tick every two clocks so single-clock valid pulses are observable.
// Outputs are sampled on the falling edge.
module tb_morse_decoder;
  logic clock;
  logic clear;

  morse_decoder_if bus ();

  morse_decoder dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] bits;
    int          len;
    logic [2:0]  code;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  int checks = 0;
  int passes = 0;

  int   vcount     = 0;
  logic [2:0] vcode = 3'd0;
  logic verr       = 1'b0;
  int   prev_valid = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Count valid pulses, capture results, and confirm each pulse lasts one clock
  always @(negedge clock) begin
    if (bus.valid === 1'b1) begin
      check("valid_width", prev_valid, 0);
      vcount++;
      vcode = bus.code;
      verr  = bus.error;
    end
    prev_valid = (bus.valid === 1'b1) ? 1 : 0;
  end

  task automatic tick(input logic b);
    bus.serial_in = b;
    bus.enable    = 1'b1;
    @(negedge clock);
    bus.enable    = 1'b0;
    @(negedge clock);
  endtask

  task automatic send(input logic [31:0] bits, input int len);
    logic [31:0] v;
    v = bits;
    for (int i = len - 1; i >= 0; i--) begin
      tick(v[i]);
    end
  endtask

  initial begin
    // Transmitter-style patterns, MSB first, each closed by a three-tick gap
    vecs[0]  = '{32'b10101000,          8, 3'd0, 1'b0}; // S ...
    vecs[1]  = '{32'b111000,            6, 3'd1, 1'b0}; // T -
    vecs[2]  = '{32'b1010111000,       10, 3'd2, 1'b0}; // U ..-
    vecs[3]  = '{32'b101010111000,     12, 3'd3, 1'b0}; // V ...-
    vecs[4]  = '{32'b101110111000,     12, 3'd4, 1'b0}; // W .--
    vecs[5]  = '{32'b11101010111000,   14, 3'd5, 1'b0}; // X -..-
    vecs[6]  = '{32'b1110101110111000, 16, 3'd6, 1'b0}; // Y -.--
    vecs[7]  = '{32'b11101110101000,   14, 3'd7, 1'b0}; // Z --..
    vecs[8]  = '{32'b110000,            6, 3'd0, 1'b1}; // two-tick mark
    vecs[9]  = '{32'b101010101000,     12, 3'd0, 1'b1}; // five dots
    vecs[10] = '{32'b1001000,           7, 3'd0, 1'b1}; // two-tick inner space
    vecs[11] = '{32'b101000,            6, 3'd0, 1'b1}; // .. not in table
    vecs[12] = '{32'b1111111111000,    13, 3'd0, 1'b1}; // saturated long mark

    // Reset with the line high and enable toggling
    clear         = 1'b0;
    bus.enable    = 1'b0;
    bus.serial_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bus.enable = ~bus.enable;
    end
    @(negedge clock);
    check("rst_code",  int'(bus.code),  0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_error", int'(bus.error), 0);
    check("rst_busy",  int'(bus.busy),  0);
    bus.enable    = 1'b0;
    bus.serial_in = 1'b0;
    clear         = 1'b1;
    vcount        = 0;
    tick(1'b0);
    check("idle_busy",  int'(bus.busy), 0);
    check("idle_valid", vcount, 0);

    // Letter and malformed-pattern table
    for (int k = 0; k < 13; k++) begin
      vcount = 0;
      send(vecs[k].bits, vecs[k].len);
      check($sformatf("vec%0d_count", k), vcount, 1);
      check($sformatf("vec%0d_code", k),  int'(vcode), int'(vecs[k].code));
      check($sformatf("vec%0d_error", k), int'(verr),  int'(vecs[k].err));
      check($sformatf("vec%0d_busy", k),  int'(bus.busy), 0);
      tick(1'b0);
    end

    // Stall mid-dash: 100 clocks with enable low and the line wiggling
    vcount = 0;
    tick(1'b1);
    tick(1'b1);
    for (int i = 0; i < 100; i++) begin
      bus.serial_in = ~bus.serial_in;
      @(negedge clock);
    end
    check("stall_busy",  int'(bus.busy), 1);
    check("stall_valid", vcount, 0);
    send(32'b1000, 4);
    check("stall_count", vcount, 1);
    check("stall_code",  int'(vcode), 1);
    check("stall_error", int'(verr),  0);

    // Reset mid-letter discards the letter
    vcount = 0;
    send(32'b101, 3);
    check("mid_busy_pre", int'(bus.busy), 1);
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    check("mid_busy_post", int'(bus.busy), 0);
    send(32'b000, 3);
    check("mid_no_valid", vcount, 0);
    send(32'b10101000, 8);
    check("post_rst_count", vcount, 1);
    check("post_rst_code",  int'(vcode), 0);
    check("post_rst_error", int'(verr),  0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
